// File: rtl/scroll_display_if.sv
// Scroll-pointer input and 7-segment pin outputs of the scrolling display driver.
interface scroll_display_if;
  logic [3:0] addr;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (output addr, input an, input seg);
  modport slave  (input addr, output an, output seg);
endinterface

// File: rtl/scroll_display_driver.sv
// Shows a 4-character window of a 16-entry hex message on a multiplexed 7-segment
// display, with a dark gap before every digit to avoid ghosting.
module scroll_display_driver #(
  parameter int unsigned DRIVE_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter logic [63:0] MSG          = 64'hFEDCBA9876543210
) (
  input logic             clk,
  input logic             reset,
  scroll_display_if.slave bus
);

  localparam int unsigned MaxCycles =
      (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(DRIVE_CYCLES - 1);

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e          state_q, state_d;
  logic [1:0]      digit_q, digit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      base_q, base_d;
  logic            started_q, started_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      char_idx;
  logic [3:0]      char_val;

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StBlank;
      digit_q   <= 2'd3;
      cnt_q     <= '0;
      base_q    <= 4'd0;
      started_q <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'h7F;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      started_q <= started_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q + CntW'(1);
    base_d    = base_q;
    started_d = 1'b1;
    if (!started_q) begin
      // First edge after reset acts as the frame-start edge: latch addr, begin BLANK.
      state_d = StBlank;
      digit_d = 2'd3;
      cnt_d   = '0;
      base_d  = bus.addr;
    end else begin
      case (state_q)
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StDrive;
            cnt_d   = '0;
          end
        end
        default: begin
          if (cnt_q == DriveLast) begin
            state_d = StBlank;
            digit_d = digit_q - 2'd1;
            cnt_d   = '0;
            if (digit_q == 2'd0) begin
              base_d = bus.addr;
            end
          end
        end
      endcase
    end
  end

  // Outputs are computed from the next state so an/seg switch on the same edge as state.
  always_comb begin
    an_d     = 4'b1111;
    seg_d    = 7'h7F;
    char_idx = base_d + {2'b00, ~digit_d};
    char_val = MSG[{char_idx, 2'b00} +: 4];
    if (state_d == StDrive) begin
      an_d  = ~(4'b0001 << digit_d);
      seg_d = hex_seg(char_val);
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule
